dir_key_conditioner: RTL

// - Input-side stage that feeds the tank-game VGA top: it turns the raw, bouncing push-buttons into clean control signals.
// - Conditioned outputs:
//     - one-hot direction[3:0], consumed by the top's direction register;
//     - fire_pulse, for the shoot logic.
// - Each button goes through a 2-flop synchronizer and a per-key debouncer.
// - When several direction keys are held, a sticky selection picks one.

---
 rtl/dir_key_conditioner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dir_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : dir_key_conditioner
// Description : Conditions the five raw, bouncing tank-game push-buttons into
//               clean control signals for the VGA top. Each button passes
//               through a 2-flop synchronizer and a per-key debouncer. The
//               four direction keys then feed a sticky one-hot selector, and
//               the fire key produces a single-cycle pulse per press.
//
//               Optional feature macro: FIRE_REPEAT_EN
//                 defined   -> fire_pulse also auto-repeats every
//                              REPEAT_CYCLES cycles while fire is held
//                 undefined -> exactly one fire_pulse per accepted press
//
// Ports       : clk_25m     in   pixel clock, rising edge
//               rst_n       in   asynchronous, active-low reset
//               key_n[4:0]  in   raw buttons, active-low
//                                [4]=up [3]=down [2]=left [1]=right [0]=fire
//               direction   out  one-hot held direction (1000 up, 0100 down,
//                                0010 left, 0001 right, 0000 none)
//               dir_change  out  1-cycle pulse when direction takes a new
//                                nonzero value
//               fire_pulse  out  1-cycle pulse on fire press / repeat
//               key_state   out  debounced pressed state, active-high
//
// Revision    : 1.0  initial release
// ============================================================================
module dir_key_conditioner #(
    parameter int DEB_CYCLES    = 250000,
    parameter int CNT_W         = 18,
    parameter int REPEAT_CYCLES = 6250000
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic [4:0] key_n,
    output logic [3:0] direction,
    output logic       dir_change,
    output logic       fire_pulse,
    output logic [4:0] key_state
);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time configuration guards
    // ------------------------------------------------------------------------
    generate
        if ((2 ** CNT_W) <= DEB_CYCLES) begin : g_bad_cnt_w
            $error("dir_key_conditioner: CNT_W too small for DEB_CYCLES");
        end
        if (REPEAT_CYCLES < 2) begin : g_bad_repeat
            $error("dir_key_conditioner: REPEAT_CYCLES must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Synchronizer: kept in the raw active-low polarity so that the reset
    // value of '1 means "released".
    // ------------------------------------------------------------------------
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_pressed;
    logic [4:0] w_key_state;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // ------------------------------------------------------------------------
    // Per-key debouncer: the counter runs only while the synchronized level
    // disagrees with the accepted state, so any disagreement shorter than
    // DEB_CYCLES cycles is forgotten as soon as the level agrees again.
    // ------------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_key
            logic [CNT_W-1:0] r_cnt;
            logic             r_state;

            always_ff @(posedge clk_25m or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_state <= 1'b0;
                end else if (w_pressed[k] == r_state) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_state <= ~r_state;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_key_state[k] = r_state;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Direction select. key_state[4:1] lines up bit-for-bit with the one-hot
    // direction encoding, so the held key can be checked with a plain AND.
    // ------------------------------------------------------------------------
    logic [3:0] r_dir;
    logic       r_dir_change;
    logic [3:0] w_sel_next;

    always_comb begin
        w_sel_next = 4'b0000;
        if ((r_dir != 4'b0000) && ((r_dir & w_key_state[4:1]) != 4'b0000)) begin
            // Sticky: the current key wins even over higher-priority keys.
            w_sel_next = r_dir;
        end else if (w_key_state[4]) begin
            w_sel_next = 4'b1000;
        end else if (w_key_state[3]) begin
            w_sel_next = 4'b0100;
        end else if (w_key_state[2]) begin
            w_sel_next = 4'b0010;
        end else if (w_key_state[1]) begin
            w_sel_next = 4'b0001;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_dir        <= 4'b0000;
            r_dir_change <= 1'b0;
        end else begin
            r_dir        <= w_sel_next;
            r_dir_change <= (w_sel_next != r_dir) && (w_sel_next != 4'b0000);
        end
    end

    // ------------------------------------------------------------------------
    // Fire: edge detect on the debounced state, plus optional auto-repeat.
    // r_fire_prev is the debounced fire level one cycle late; the repeat
    // counter starts on the cycle after the press pulse so that repeats land
    // exactly REPEAT_CYCLES cycles after the previous pulse.
    // ------------------------------------------------------------------------
    logic r_fire_prev;
    logic r_fire_pulse;
    logic w_fire_rise;
    logic w_fire_repeat;

    assign w_fire_rise = w_key_state[0] & ~r_fire_prev;

`ifdef FIRE_REPEAT_EN
    localparam int RC_W = $clog2(REPEAT_CYCLES);
    localparam logic [RC_W-1:0] c_rc_last = RC_W'(REPEAT_CYCLES - 1);

    logic [RC_W-1:0] r_rc;

    assign w_fire_repeat = w_key_state[0] & r_fire_prev & (r_rc == c_rc_last);

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_rc <= '0;
        end else if (!(w_key_state[0] && r_fire_prev) || w_fire_repeat) begin
            r_rc <= '0;
        end else begin
            r_rc <= r_rc + 1'b1;
        end
    end
`else
    assign w_fire_repeat = 1'b0;
`endif

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_fire_prev  <= 1'b0;
            r_fire_pulse <= 1'b0;
        end else begin
            r_fire_prev  <= w_key_state[0];
            r_fire_pulse <= w_fire_rise | w_fire_repeat;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign key_state  = w_key_state;
    assign direction  = r_dir;
    assign dir_change = r_dir_change;
    assign fire_pulse = r_fire_pulse;

endmodule
`default_nettype wire
